bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq.sv | 140 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter (optional BIN2BCD_SEVENSEG_EN)
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
`ifdef BIN2BCD_SEVENSEG_EN
    ,
    output logic [6:0]            seg_ones,
    output logic [6:0]            seg_tens
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int CAT_W = 4 * DIGITS + WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [WIDTH-1:0]      shreg;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   scratch_adj;
    logic [CAT_W-1:0]      cat_next;
    logic [CNT_W-1:0]      cnt;
    logic                  load_en;
    logic                  shift_en;
    logic                  fin_en;
    logic                  ovf_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_W'(1)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ST_SHIFT);
        load_en  = (state == ST_IDLE) && start;
        shift_en = (state == ST_SHIFT);
        fin_en   = (state == ST_DONE);
    end

    // Add-3 correction precedes the shift so every nibble stays within 0..9 afterwards.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        cat_next = {scratch_adj, shreg} << 1;
    end

    assign ovf_next = |scratch[4*DIGITS-1:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
        end else if (load_en) begin
            shreg   <= bin_in;
            scratch <= '0;
            cnt     <= CNT_W'(WIDTH);
        end else if (shift_en) begin
            shreg   <= cat_next[WIDTH-1:0];
            scratch <= cat_next[CAT_W-1:WIDTH];
            cnt     <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= fin_en;
            if (fin_en) begin
                bcd_out <= scratch;
                ovf     <= ovf_next;
            end
        end
    end

`ifdef BIN2BCD_SEVENSEG_EN
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0001100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Segments blank whenever the value cannot be shown on two digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_ones <= 7'b1111111;
            seg_tens <= 7'b1111111;
        end else if (fin_en) begin
            seg_ones <= ovf_next ? 7'b1111111 : seg_of(scratch[3:0]);
            seg_tens <= ovf_next ? 7'b1111111 : seg_of(scratch[7:4]);
        end
    end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard testbench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic        ovf;
`ifdef BIN2BCD_SEVENSEG_EN
    logic [6:0]  seg_ones;
    logic [6:0]  seg_tens;
`endif

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
`ifdef BIN2BCD_SEVENSEG_EN
        ,
        .seg_ones(seg_ones),
        .seg_tens(seg_tens)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [11:0] exp_q[$];
    logic        exp_ovf_q[$];
    logic [6:0]  seg_tab[10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    task automatic push_exp(input int v);
        exp_q.push_back(ref_bcd(v));
        exp_ovf_q.push_back(v > 99);
    endtask

    task automatic check_result();
        logic [11:0] e;
        logic        eo;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e  = exp_q.pop_front();
            eo = exp_ovf_q.pop_front();
            check("bcd_out", bcd_out, e);
            check("ovf", ovf, eo);
`ifdef BIN2BCD_SEVENSEG_EN
            check("seg_ones", seg_ones, eo ? 7'b1111111 : seg_tab[e[3:0]]);
            check("seg_tens", seg_tens, eo ? 7'b1111111 : seg_tab[e[7:4]]);
`endif
        end
    endtask

    task automatic run_conv(input int v);
        int k;
        int busy_cnt;
        bit seen;
        bin_in = 8'(v);
        start  = 1'b1;
        push_exp(v);
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = busy ? 1 : 0;
        k        = 0;
        seen     = 0;
        while (k < 40 && !seen) begin
            @(negedge clk);
            k++;
            if (busy) busy_cnt++;
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        check("latency_edges", k, 9);
        check("busy_cycles", busy_cnt, 8);
        if (seen) check_result();
        @(negedge clk);
        check("done_one_cycle", done, 0);
        repeat (2) @(negedge clk);
        check("bcd_hold", bcd_out, ref_bcd(v));
    endtask

    initial begin
        int k;
        int pulses;
        int busy_seen;
        bit seen;

        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_ovf", ovf, 0);
`ifdef BIN2BCD_SEVENSEG_EN
        check("rst_seg_ones", seg_ones, 7'b1111111);
        check("rst_seg_tens", seg_tens, 7'b1111111);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        run_conv(0);
        run_conv(99);
        run_conv(100);
        run_conv(9);
        run_conv(10);

        // start held high: 255 then 37 back-to-back
        bin_in = 8'd255;
        start  = 1'b1;
        push_exp(255);
        k = 0; seen = 0;
        while (k < 40 && !seen) begin
            @(negedge clk);
            k++;
            if (done) seen = 1;
        end
        check("b2b_first_seen", seen, 1);
        if (seen) check_result();
        bin_in = 8'd37;
        push_exp(37);
        k = 0; seen = 0;
        while (k < 40 && !seen) begin
            @(negedge clk);
            k++;
            if (done) seen = 1;
        end
        start = 1'b0;
        check("b2b_second_seen", seen, 1);
        check("b2b_spacing", k, 10);
        if (seen) check_result();
        repeat (3) @(negedge clk);

        // start during SHIFT is ignored
        bin_in = 8'd42;
        start  = 1'b1;
        push_exp(42);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        bin_in = 8'd200;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 8'd0;
        k = 0; seen = 0;
        while (k < 40 && !seen) begin
            @(negedge clk);
            k++;
            if (done) seen = 1;
        end
        check("ign_done_seen", seen, 1);
        if (seen) check_result();
        pulses = 0; busy_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) pulses++;
            if (busy) busy_seen++;
        end
        check("ign_no_second_done", pulses, 0);
        check("ign_no_second_busy", busy_seen, 0);

        // reset during shift cycle 4
        bin_in = 8'd200;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_bcd", bcd_out, 0);
        check("abort_ovf", ovf, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run_conv(7);

        for (int i = 0; i < 4; i++) begin
            run_conv(int'($urandom_range(0, 255)));
        end
        run_conv(255);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
